// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - request front-end for a banked single-port SRAM with read response FIFO
// Drives the bank pins combinationally on fire and queues read data so a stalled consumer loses nothing.

module sram_bank_ctrl_rsp_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_tvalid,
  input  logic [WIDTH-1:0]           in_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [WIDTH-1:0]           out_tdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign out_tvalid = (count != '0);
  assign pop        = out_tvalid & out_tready;
  // Head is masked when empty so the outputs read zero after reset without clearing storage.
  assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (in_tvalid) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({in_tvalid, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (in_tvalid) mem[wr_ptr] <= in_tdata;
  end
endmodule

module sram_bank_ctrl #(
  parameter int ADDR_WIDTH      = 13,
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int NUM_BANKS       = 6,
  parameter int DATA_WIDTH      = 16,
  parameter int RSP_DEPTH       = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [$clog2(RSP_DEPTH):0]    rsp_count,
  output logic [ADDR_WIDTH-1:0]         A,
  output logic                          CEB,
  output logic                          WEB,
  output logic [DATA_WIDTH-1:0]         D,
  input  logic [DATA_WIDTH-1:0]         Q
);
  localparam int SW = ADDR_WIDTH - BANK_ADDR_WIDTH;
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic [SW:0]           bank_sel;
  logic                  oor;
  logic [CW:0]           credit_used;
  logic                  rd_room;
  logic                  fire;
  logic                  rd_fire;
  logic                  rd_inflight;
  logic                  rd_oor;
  logic [DATA_WIDTH:0]   push_tdata;

  assign bank_sel = {1'b0, req_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH]};
  assign oor      = (bank_sel >= (SW+1)'(NUM_BANKS));

  // A read still in the bank pipeline already owns a FIFO slot; a same-cycle pop does not free one.
  assign credit_used = {1'b0, rsp_count} + (CW+1)'(rd_inflight);
  assign rd_room     = (credit_used < (CW+1)'(RSP_DEPTH));
  assign req_ready   = ~RST & (req_write | rd_room);

  assign fire    = req_valid & req_ready;
  assign rd_fire = fire & ~req_write;

  assign CEB = ~(fire & ~oor);
  assign WEB = ~req_write;
  assign A   = req_addr;
  assign D   = req_wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_inflight <= 1'b0;
      rd_oor      <= 1'b0;
    end else begin
      rd_inflight <= rd_fire;
      if (rd_fire) rd_oor <= oor;
    end
  end

  assign push_tdata = {rd_oor, rd_oor ? {DATA_WIDTH{1'b0}} : Q};

  sram_bank_ctrl_rsp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .in_tvalid  (rd_inflight),
    .in_tdata   (push_tdata),
    .out_tvalid (rsp_valid),
    .out_tready (rsp_ready),
    .out_tdata  ({rsp_err, rsp_rdata}),
    .count      (rsp_count)
  );
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - scoreboard bench for sram_bank_ctrl with a behavioural bank model
module tb_sram_bank_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_write;
  logic [12:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_count;
  logic [12:0] A;
  logic        CEB, WEB;
  logic [15:0] D, Q;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  always #5 CLK = ~CLK;

  sram_bank_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_count(rsp_count),
    .A(A), .CEB(CEB), .WEB(WEB), .D(D), .Q(Q)
  );

  function automatic logic [15:0] exp_data(input int a);
    return 16'(a) ^ 16'hC35A;
  endfunction

  // Bank model: unwritten words return the preload pattern exp_data(addr).
  logic [15:0] wmem [0:6143];
  bit          written [0:6143];
  always @(posedge CLK) begin
    if (!CEB && int'(A) < 6144) begin
      if (!WEB) begin
        wmem[A]    <= D;
        written[A] <= 1'b1;
      end else begin
        Q <= written[A] ? wmem[A] : exp_data(int'(A));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stale_rsp: got err=%0b data=%h required no response", rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", {15'd0, rsp_err, rsp_rdata}, {15'd0, mon_e});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic [12:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic do_req(input logic w, input logic [12:0] a, input logic [15:0] d, input logic [16:0] e);
    bit done;
    done = 1'b0;
    drive(w, a, d);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (req_ready) begin
        done = 1'b1;
        if (!w) exp_q.push_back(e);
      end
      step();
    end
    req_valid = 1'b0;
    chk("req_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !rsp_valid && rsp_count == 2'd0) break;
      step();
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  logic [3:0] stall_acc_exp;
  logic       acc;

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    @(posedge CLK); step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_count", {30'd0, rsp_count}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_ceb",       {31'd0, CEB}, 32'd1);
    chk("rst_web",       {31'd0, WEB}, 32'd1);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    step();

    // Write then read-back with latency checks
    drive(1'b1, 13'h0005, 16'hBEEF);
    #1;
    chk("wr_ceb", {31'd0, CEB}, 32'd0);
    chk("wr_web", {31'd0, WEB}, 32'd0);
    step();
    drive(1'b0, 13'h0005, 16'h0000);
    #1;
    chk("rd_ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, 16'hBEEF});
    step();
    req_valid = 1'b0;
    chk("lat_n1_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lat_n2_data",  {16'd0, rsp_rdata}, 32'h0000BEEF);
    wait_drain();

    // Out-of-range filtering
    drive(1'b1, 13'h1C00, 16'h1234);
    #1;
    chk("oor_wr_ceb",   {31'd0, CEB}, 32'd1);
    chk("oor_wr_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    do_req(1'b0, 13'h1C00, 16'h0, {1'b1, 16'h0000});
    do_req(1'b0, 13'h1400, 16'h0, {1'b0, 16'hD75A});
    wait_drain();

    // Stalled consumer: only RSP_DEPTH reads accepted, writes still go through
    rsp_ready = 1'b0;
    stall_acc_exp = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 13'h0200 + 13'(k), 16'h0);
      #1;
      acc = req_ready;
      chk("stall_acc", {31'd0, acc}, {31'd0, stall_acc_exp[k]});
      if (acc) exp_q.push_back({1'b0, exp_data(32'h200 + k)});
      step();
    end
    chk("stall_count", {30'd0, rsp_count}, 32'd2);
    #1;
    chk("stall_rd_ready", {31'd0, req_ready}, 32'd0);
    drive(1'b1, 13'h0100, 16'hCAFE);
    #1;
    chk("stall_wr_ready", {31'd0, req_ready}, 32'd1);
    chk("stall_wr_ceb",   {31'd0, CEB}, 32'd0);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    do_req(1'b0, 13'h0202, 16'h0, {1'b0, exp_data(32'h202)});
    do_req(1'b0, 13'h0203, 16'h0, {1'b0, exp_data(32'h203)});
    wait_drain();

    // Streaming reads across all macros, pointer wrap
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 13'(i * 384 + 3), 16'h0, {1'b0, exp_data(i * 384 + 3)});
    wait_drain();

    // Simultaneous push and pop at occupancy 1
    rsp_ready = 1'b0;
    drive(1'b0, 13'h0300, 16'h0);
    #1;
    chk("pp_x_ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, exp_data(32'h300)});
    step();
    drive(1'b0, 13'h0301, 16'h0);
    #1;
    chk("pp_y_ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, exp_data(32'h301)});
    step();
    req_valid = 1'b0;
    chk("pp_count_before", {30'd0, rsp_count}, 32'd1);
    rsp_ready = 1'b1;
    step();
    chk("pp_count_after", {30'd0, rsp_count}, 32'd1);
    chk("pp_valid_after", {31'd0, rsp_valid}, 32'd1);
    wait_drain();
    do_req(1'b0, 13'h0100, 16'h0, {1'b0, 16'hCAFE});
    wait_drain();

    // Reset one cycle after a read fire
    drive(1'b0, 13'h0010, 16'h0);
    #1;
    chk("rr_ready", {31'd0, req_ready}, 32'd1);
    step();
    RST = 1'b1;
    #1;
    chk("rr_ceb_in_rst",   {31'd0, CEB}, 32'd1);
    chk("rr_ready_in_rst", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    step();
    step();
    RST = 1'b0;
    #1;
    chk("rr_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rr_count", {30'd0, rsp_count}, 32'd0);
    chk("rr_ceb",   {31'd0, CEB}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_no_stale", {31'd0, rsp_valid}, 32'd0);
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
